bus_timer_responder: RTL and testbench



---
 rtl/bus_timer_responder.sv | 198 +++++++++++++++++++
 tb/tb_bus_timer_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_responder.sv
// Strobe/ack bus responder with a memory-mapped, prescaled, down-counting timer.
// The register window is decoded locally; the timer raises a level interrupt on underflow.
module bus_timer_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFE0,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRESC_W     = 16
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  localparam logic [3:0] WaitInit  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegLoad   = 3'd1;
  localparam logic [2:0] RegCount  = 3'd2;
  localparam logic [2:0] RegPresc  = 3'd3;
  localparam logic [2:0] RegStatus = 3'd4;

  state_e              state_q;
  logic [3:0]          wcnt_q;
  logic                we_q;
  logic [2:0]          reg_q;
  logic [31:0]         wdat_q;
  logic [3:0]          sel_q;
  logic                ack_q;
  logic [31:0]         rdat_q;
  logic                irq_q;
  logic [2:0]          ctrl_q;    // {RELOAD, IE, EN}
  logic [31:0]         load_q;
  logic [31:0]         count_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [PRESC_W-1:0]  pcnt_q;
  logic                pend_q;

  logic                hit;
  logic                access;
  logic                acc_we;
  logic [2:0]          acc_reg;
  logic [31:0]         acc_dat;
  logic [3:0]          acc_sel;
  logic [31:0]         rd_mux;
  logic [PRESC_W-1:0]  presc_nx;
  logic                tick;
  logic                wr_ctrl, wr_load, wr_count, wr_presc, wr_status;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = sel[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

  assign hit = stb_i && ((adr_i & ADDR_MASK) == BASE_ADDR);

  // The access fires on the edge that enters StAck; with no wait states it uses the live bus.
  always_comb begin
    access  = 1'b0;
    acc_we  = we_q;
    acc_reg = reg_q;
    acc_dat = wdat_q;
    acc_sel = sel_q;
    unique case (state_q)
      StIdle: begin
        if (hit && (WAIT_STATES == 0)) begin
          access  = 1'b1;
          acc_we  = we_i;
          acc_reg = adr_i[4:2];
          acc_dat = dat_i;
          acc_sel = sel_i;
        end
      end
      StWait:  access = stb_i && (wcnt_q == 4'd0);
      default: ;
    endcase
  end

  assign wr_ctrl   = access && acc_we && (acc_reg == RegCtrl);
  assign wr_load   = access && acc_we && (acc_reg == RegLoad);
  assign wr_count  = access && acc_we && (acc_reg == RegCount);
  assign wr_presc  = access && acc_we && (acc_reg == RegPresc);
  assign wr_status = access && acc_we && (acc_reg == RegStatus);

  always_comb begin
    rd_mux = '0;
    case (acc_reg)
      RegCtrl:   rd_mux = {29'd0, ctrl_q};
      RegLoad:   rd_mux = load_q;
      RegCount:  rd_mux = count_q;
      RegPresc:  rd_mux = 32'(presc_q);
      RegStatus: rd_mux = {31'd0, pend_q};
      default:   rd_mux = '0;
    endcase
  end

  always_comb begin
    presc_nx = presc_q;
    for (int b = 0; b < int'(PRESC_W); b++) begin
      if (acc_sel[b/8]) presc_nx[b] = acc_dat[b];
    end
  end

  assign tick = ctrl_q[0] && (pcnt_q == presc_q);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      reg_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            we_q   <= we_i;
            reg_q  <= adr_i[4:2];
            wdat_q <= dat_i;
            sel_q  <= sel_i;
            if (WAIT_STATES == 0) begin
              state_q <= StAck;
            end else begin
              state_q <= StWait;
              wcnt_q  <= WaitInit;
            end
          end
        end
        StWait: begin
          if (!stb_i)                state_q <= StIdle;
          else if (wcnt_q == 4'd0)   state_q <= StAck;
          else                       wcnt_q  <= wcnt_q - 4'd1;
        end
        StAck: begin
          if (!stb_i) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (access) begin
        ack_q  <= 1'b1;
        rdat_q <= acc_we ? 32'd0 : rd_mux;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q  <= pend_q & ctrl_q[1];
      pcnt_q <= (!ctrl_q[0] || tick || wr_presc) ? '0 : pcnt_q + 1'b1;
      // Later assignments win: a PEND set beats W1C, bus writes beat timer updates.
      if (wr_status && acc_sel[0] && acc_dat[0]) pend_q <= 1'b0;
      if (tick) begin
        if (count_q != 32'd0) begin
          count_q <= count_q - 32'd1;
        end else begin
          pend_q <= 1'b1;
          if (ctrl_q[2]) count_q   <= load_q;
          else           ctrl_q[0] <= 1'b0;
        end
      end
      if (wr_ctrl && acc_sel[0]) ctrl_q  <= acc_dat[2:0];
      if (wr_load)               load_q  <= merge(load_q, acc_dat, acc_sel);
      if (wr_count)              count_q <= merge(count_q, acc_dat, acc_sel);
      if (wr_presc)              presc_q <= presc_nx;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = rdat_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Bench for bus_timer_responder: directed scenarios plus random bus traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_bus_timer_responder;

  localparam int unsigned WS    = 1;
  localparam int unsigned PW    = 16;
  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam logic [31:0] MASK  = 32'hFFFF_FFE0;
  localparam logic [31:0] PMASK = (PW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << PW) - 32'd1);

  logic        clk    = 1'b0;
  logic        rst_ni = 1'b1;
  logic        stb_i  = 1'b0;
  logic        we_i   = 1'b0;
  logic [31:0] adr_i  = '0;
  logic [31:0] dat_i  = '0;
  logic [3:0]  sel_i  = '0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        irq_o;

  int          vectors = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;
  bit          cmp_on  = 1'b0;
  int          last_lat;
  int unsigned last_ack_cyc;
  logic [31:0] rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_timer_responder #(
    .BASE_ADDR  (BASE),
    .ADDR_MASK  (MASK),
    .WAIT_STATES(WS),
    .PRESC_W    (PW)
  ) dut (
    .clk   (clk),
    .rst_ni(rst_ni),
    .stb_i (stb_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .sel_i (sel_i),
    .ack_o (ack_o),
    .dat_o (dat_o),
    .irq_o (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count, m_presc, m_dat, m_adr, m_wdat;
  logic        m_pend, m_irq, m_ack, m_we;
  logic [3:0]  m_sel;
  int unsigned m_el;     // enabled clocks since the prescaler last restarted
  int          m_run;    // consecutive strobe-high samples of the current hit
  bit          m_busy;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m = '0;
    for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
    return (o & ~m) | (n & m);
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_load = '0; m_count = '0; m_presc = '0; m_dat = '0; m_adr = '0;
    m_wdat = '0; m_pend = 1'b0; m_irq = 1'b0; m_ack = 1'b0; m_we = 1'b0; m_sel = '0;
    m_el = 0; m_run = 0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic        acc, tick, set, n_pend;
    logic [2:0]  n_ctrl;
    logic [31:0] rv, n_count, n_load, n_presc;
    int unsigned n_el;
    acc = 1'b0;
    if (!m_busy) begin
      if (m_run == 0) begin
        if (stb_i && ((adr_i & MASK) == BASE)) begin
          m_run = 1; m_adr = adr_i; m_we = we_i; m_wdat = dat_i; m_sel = sel_i;
        end
      end else if (stb_i) m_run++;
      else m_run = 0;
      if (m_run == int'(WS) + 1) begin acc = 1'b1; m_run = 0; m_busy = 1'b1; end
    end else if (!stb_i) begin
      m_busy = 1'b0; m_ack = 1'b0; m_dat = '0;
    end
    case (m_adr[4:2])
      3'd0:    rv = {29'd0, m_ctrl};
      3'd1:    rv = m_load;
      3'd2:    rv = m_count;
      3'd3:    rv = m_presc;
      3'd4:    rv = {31'd0, m_pend};
      default: rv = '0;
    endcase
    if (acc) begin m_ack = 1'b1; m_dat = m_we ? 32'd0 : rv; end

    tick = m_ctrl[0] && ((m_el % (m_presc + 1)) == m_presc);
    set  = tick && (m_count == 0);
    n_ctrl = m_ctrl; n_count = m_count; n_load = m_load; n_presc = m_presc; n_pend = m_pend;
    n_el = m_ctrl[0] ? m_el + 1 : 0;
    if (tick) begin
      if (m_count != 0) n_count = m_count - 1;
      else begin
        n_pend = 1'b1;
        if (m_ctrl[2]) n_count = m_load;
        else           n_ctrl[0] = 1'b0;
      end
    end
    if (acc && m_we) begin
      case (m_adr[4:2])
        3'd0: if (m_sel[0]) n_ctrl = m_wdat[2:0];
        3'd1: n_load  = lanes(m_load, m_wdat, m_sel);
        3'd2: n_count = lanes(m_count, m_wdat, m_sel);
        3'd3: begin n_presc = lanes(m_presc, m_wdat, m_sel) & PMASK; n_el = 0; end
        3'd4: if (m_sel[0] && m_wdat[0] && !set) n_pend = 1'b0;
        default: ;
      endcase
    end
    m_irq = m_pend & m_ctrl[1];
    m_ctrl = n_ctrl; m_count = n_count; m_load = n_load; m_presc = n_presc;
    m_pend = n_pend; m_el = n_el;
  endtask

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) model_reset();
    else         model_step();
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("ack_o", {31'd0, ack_o}, {31'd0, m_ack});
      check("dat_o", dat_o, m_dat);
      check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [3:0] sel, input int hold, input bit exp_ack,
                     output logic [31:0] rdata);
    bit acked = 1'b0;
    @(posedge clk); #1;
    stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; sel_i = sel;
    rdata = '0;
    for (int i = 1; i <= 20 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        acked = 1'b1; last_lat = i; last_ack_cyc = cyc; rdata = dat_o;
      end
    end
    check("ack_seen", {31'd0, acked}, {31'd0, exp_ack});
    repeat (hold) begin @(posedge clk); #1; end
    stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] unused;
    bus(1'b1, BASE | 32'(off), d, 4'hF, 0, 1'b1, unused);
  endtask

  task automatic rdr(input logic [4:0] off, output logic [31:0] d);
    bus(1'b0, BASE | 32'(off), 32'd0, 4'hF, 0, 1'b1, d);
  endtask

  task automatic abort_wr(input logic [4:0] off, input logic [31:0] d);
    @(posedge clk); #1;
    stb_i = 1'b1; we_i = 1'b1; adr_i = BASE | 32'(off); dat_i = d; sel_i = 4'hF;
    @(posedge clk); #1;
    stb_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic wait_irq(output bit seen, output int unsigned when);
    seen = 1'b0; when = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (irq_o) begin seen = 1'b1; when = cyc; end
    end
  endtask

  initial begin
    bit          seen;
    int unsigned t_irq, ta, tc, td;
    bit          acked;
    #2 rst_ni = 1'b0;
    #1 cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Reset in the middle of an acknowledged access.
    @(posedge clk); #1;
    stb_i = 1'b1; we_i = 1'b1; adr_i = BASE | 32'h4; dat_i = 32'hCAFE_F00D; sel_i = 4'hF;
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack_o) acked = 1'b1;
    end
    check("pre_reset_ack", {31'd0, acked}, 32'd1);
    rst_ni = 1'b0; stb_i = 1'b0;
    #1 check("reset_drops_ack", {31'd0, ack_o}, 32'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    rdr(5'h00, rd); check("rst_ctrl", rd, 32'd0);
    rdr(5'h08, rd); check("rst_count", rd, 32'd0);
    rdr(5'h04, rd); check("rst_load", rd, 32'd0);

    // Handshake latency and readback.
    bus(1'b1, 32'hF000_0004, 32'h1234_5678, 4'hF, 2, 1'b1, rd);
    check("ack_latency", 32'(last_lat), 32'd2);
    rdr(5'h04, rd); check("load_readback", rd, 32'h1234_5678);

    // Byte lanes and an address miss.
    wr(5'h04, 32'd0);
    bus(1'b1, BASE | 32'h4, 32'hAABB_CCDD, 4'b0001, 0, 1'b1, rd);
    rdr(5'h04, rd); check("byte_lane", rd, 32'h0000_00DD);
    bus(1'b1, 32'hF000_0040, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, rd);
    rdr(5'h00, rd); check("miss_no_write", rd, 32'd0);
    rdr(5'h18, rd); check("reserved_reads_0", rd, 32'd0);

    // Aborted write leaves COUNT alone.
    wr(5'h08, 32'd7);
    abort_wr(5'h08, 32'h55);
    rdr(5'h08, rd); check("abort_no_write", rd, 32'd7);

    // One-shot: 4 ticks of 2 clocks, then PEND, irq a cycle later.
    wr(5'h0C, 32'd1);
    wr(5'h08, 32'd3);
    wr(5'h00, 32'b011);
    ta = last_ack_cyc;
    wait_irq(seen, t_irq);
    check("oneshot_irq_seen", {31'd0, seen}, 32'd1);
    check("oneshot_irq_delay", t_irq - ta, 32'd9);
    rdr(5'h00, rd); check("oneshot_en_clear", rd, 32'd2);
    rdr(5'h10, rd); check("oneshot_pend", rd, 32'd1);
    rdr(5'h08, rd); check("oneshot_count0", rd, 32'd0);
    wr(5'h10, 32'd1);
    check("w1c_irq_low", {31'd0, irq_o}, 32'd0);

    // Auto-reload every 3 clocks, with W1C writes at several phases.
    wr(5'h04, 32'd2);
    wr(5'h08, 32'd0);
    wr(5'h0C, 32'd0);
    wr(5'h00, 32'b111);
    ta = last_ack_cyc;
    wait_irq(seen, t_irq);
    check("reload_irq_delay", t_irq - ta, 32'd2);
    for (int g = 0; g < 4; g++) begin
      repeat (g) @(posedge clk);
      wr(5'h10, 32'd1);
    end
    wr(5'h00, 32'd0);
    wr(5'h10, 32'd1);

    // COUNT writes landing on tick cycles win over the decrement.
    wr(5'h08, 32'd100);
    wr(5'h00, 32'd1);
    ta = last_ack_cyc;
    wr(5'h08, 32'd50);
    tc = last_ack_cyc;
    wr(5'h00, 32'd0);
    td = last_ack_cyc;
    rdr(5'h08, rd); check("count_write_wins", rd, 32'd50 - (td - tc));
    if (tc - ta >= 100) check("collision_window", tc - ta, 32'd0);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      int          kind;
      int          off;
      logic [31:0] a, d;
      logic [3:0]  s;
      kind = $urandom_range(0, 11);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (kind == 0) begin
        a = $urandom;
        if ((a & MASK) == BASE) a = a ^ 32'h8000_0000;
        bus(1'($urandom_range(0, 1)), a, $urandom, 4'hF, 0, 1'b0, rd);
      end else if (kind == 1) begin
        abort_wr(5'($urandom_range(0, 7) * 4), $urandom);
      end else begin
        off = $urandom_range(0, 7);
        a = BASE | 32'(off * 4) | 32'($urandom_range(0, 3));
        case (off)
          1, 2:    d = 32'($urandom_range(0, 12));
          3:       d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
          default: d = $urandom;
        endcase
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        bus(1'($urandom_range(0, 1)), a, d, s, $urandom_range(0, 3), 1'b1, rd);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
